ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Drives the open-drain kclk/kdata lines through output-enables; top level ties the pads low when *_oe=1.
//  Sits beside the PS/2 receiver on the same pads; the receiver ignores traffic while busy=1.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock frequency
//  INHIBIT_US   100          host clock-inhibit time before the start bit
//  TIMEOUT_US   2000         max gap between device clock falling edges before abort
//  FILTER_LEN   8            consecutive equal samples required to accept a line level
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  tx_data    in   8  command byte
//  tx_valid   in   1  request; accepted when tx_valid & tx_ready
//  tx_ready   out  1  high only in IDLE
//  kclk_in    in   1  PS/2 clock pad level (asynchronous)
//  kdata_in   in   1  PS/2 data pad level (asynchronous)
//  kclk_oe    out  1  1 = pull clock pad low
//  kdata_oe   out  1  1 = pull data pad low
//  busy       out  1  high from accept until done/err
//  done       out  1  one-cycle pulse: byte sent and ACK received
//  err        out  1  one-cycle pulse: transfer aborted
//  err_code   out  2  valid with err: 01 timeout, 10 no ACK, 11 line contention
// BEHAVIOUR
//  - Reset: kclk_oe=0, kdata_oe=0, tx_ready=1, busy=0, done=0, err=0, err_code=00, state IDLE.
//    rst mid-transfer releases both lines on the next edge; no done/err pulse.
//  - Input path: 2-flop synchronizer, then filter (level changes after FILTER_LEN equal samples).
//    Falling edge = filtered kclk 1->0; latency from pad to edge strobe is 2+FILTER_LEN cycles.
//  - On accept: latch tx_data, compute odd parity P = ~^tx_data, go to INHIBIT.
//  - INHIBIT: kclk_oe=1 for INHIBIT_US*CLK_FREQ_HZ/1e6 cycles; in the last cycle assert kdata_oe=1 (start bit).
//  - REQ: kclk_oe=0, kdata_oe=1; wait for falling edge #1.
//  - DATA: falling edge n (n=1..8) drives bit n-1, LSB first; kdata_oe = ~bit.
//    Edge 9 drives P. Edge 10 sets kdata_oe=0 (stop bit, line released).
//  - ACK: at falling edge 11, sample filtered kdata: 0 -> WAIT_IDLE; 1 -> err, err_code=10.
//  - WAIT_IDLE: wait until filtered kclk=1 and kdata=1, then pulse done, go to IDLE (tx_ready=1 next cycle).
//  - Timeout counter is cleared on accept and on every falling edge; it counts in REQ/DATA/ACK/WAIT_IDLE.
//    At TIMEOUT_US*CLK_FREQ_HZ/1e6 cycles: release both lines, pulse err with err_code=01, go to IDLE.
//  - Every abort releases both oe outputs in the same cycle err is asserted.
//  - tx_valid while busy is ignored; tx_data is not re-sampled mid-transfer.
//  - Bit index is 4 bits and never wraps; edges after #11 are ignored until IDLE.
//  - Counters are sized with $clog2 of the computed cycle counts; no truncation at defaults.
// CONFIGURATION
//  PS2_TX_LINE_CHECK_EN defined:
//    on each filtered kclk rising edge during DATA/parity, compare kdata_in with the driven bit.
//    Mismatch -> release lines, pulse err, err_code=11.
//  Not defined: no compare; err_code 11 is never produced.
// TESTING
//  - Send 0xED, device model clocks 11 edges, ACK=0 -> data bits 1,0,1,1,0,1,1,1, parity 1, stop released,
//    done pulses once, busy falls.
//  - Send 0x01 -> parity bit 0; kclk_oe held low exactly 10_000 cycles at defaults before release.
//  - Device never clocks after REQ -> err with err_code=01 after 200_000 cycles; kclk_oe=kdata_oe=0.
//  - Device leaves data high at edge 11 -> err, err_code=10, no done.
//  - rst asserted at edge 5 of 0xFF -> both oe=0 next cycle, tx_ready=1, no pulses;
//    a new send of 0xF4 then completes.
//  - With PS2_TX_LINE_CHECK_EN: model forces kdata=0 while bit 2 of 0xFF is driven -> err, err_code=11.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Drives the open-drain kclk/kdata pads through output enables, clocks one
// byte + odd parity + stop out on device clock falling edges, checks the ACK.
// Optional build macro PS2_TX_LINE_CHECK_EN: compare the data pad with the
// driven bit on each device clock rising edge and abort on contention.
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 2000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    // Cycle counts are computed in 64 bits so large clock/time products do not overflow.
    localparam longint INH_CYC = (longint'(INHIBIT_US) * longint'(CLK_FREQ_HZ)) / 64'sd1_000_000;
    localparam longint TO_CYC  = (longint'(TIMEOUT_US) * longint'(CLK_FREQ_HZ)) / 64'sd1_000_000;
    localparam int INH_W = $clog2(INH_CYC + 1);
    localparam int TO_W  = $clog2(TO_CYC + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INH_CYC - 1);
    localparam logic [INH_W-1:0] INH_START = INH_W'(INH_CYC - 2);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);
    localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FILTER_LEN - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] DATA      = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    logic [2:0]       state;
    logic [9:0]       frame;      // {stop, parity, data}, shifted out LSB first
    logic [3:0]       bit_idx;    // falling edges seen in this transfer
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;

    // index 0 = clock pad, index 1 = data pad
    logic [1:0]       s1, s2, filt, filt_d;
    logic [FLT_W-1:0] fcnt [2];
    logic             fall, active;
    logic             abort_req;
    logic [1:0]       abort_code;

    // Synchronize both pads, then accept a new level only after FILTER_LEN equal samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 2'b11;
            s2      <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            s1     <= {kdata_in, kclk_in};
            s2     <= s1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FLT_LAST) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FLT_W'(1);
                end
            end
        end
    end

    assign fall     = filt_d[0] & ~filt[0];
    assign active   = (state == REQ) | (state == DATA) | (state == ACK) | (state == WAIT_IDLE);
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

`ifdef PS2_TX_LINE_CHECK_EN
    logic rise;
    assign rise = ~filt_d[0] & filt[0];
`endif

    // Abort decisions: timeout, line contention (optional), missing ACK.
    always_comb begin
        abort_req  = 1'b0;
        abort_code = 2'b00;
        if (active && !fall && to_cnt == TO_LAST) begin
            abort_req  = 1'b1;
            abort_code = 2'b01;
`ifdef PS2_TX_LINE_CHECK_EN
        // synchronized pad should read the driven bit (~kdata_oe) while the device clock is high
        end else if (state == DATA && rise && s2[1] == kdata_oe) begin
            abort_req  = 1'b1;
            abort_code = 2'b11;
`endif
        end else if (state == ACK && fall && filt[1]) begin
            abort_req  = 1'b1;
            abort_code = 2'b10;
        end
    end

    // Transfer sequencer: inhibit, request-to-send, bit shifting, ACK, bus-idle wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            frame    <= '0;
            bit_idx  <= '0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (active)
                to_cnt <= fall ? '0 : to_cnt + TO_W'(1);
            if (abort_req) begin
                state    <= IDLE;
                kclk_oe  <= 1'b0;
                kdata_oe <= 1'b0;
                err      <= 1'b1;
                err_code <= abort_code;
            end else begin
                case (state)
                    IDLE: if (tx_valid) begin
                        frame   <= {1'b1, ~^tx_data, tx_data};
                        bit_idx <= '0;
                        inh_cnt <= '0;
                        to_cnt  <= '0;
                        kclk_oe <= 1'b1;
                        state   <= INHIBIT;
                    end
                    INHIBIT: begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                        // start bit goes low in the final inhibit cycle
                        if (inh_cnt == INH_START)
                            kdata_oe <= 1'b1;
                        if (inh_cnt == INH_LAST) begin
                            kclk_oe  <= 1'b0;
                            kdata_oe <= 1'b1;
                            state    <= REQ;
                        end
                    end
                    REQ, DATA: if (fall) begin
                        kdata_oe <= ~frame[0];
                        frame    <= {1'b1, frame[9:1]};
                        bit_idx  <= bit_idx + 4'd1;
                        if (state == REQ)
                            state <= DATA;
                        else if (bit_idx == 4'd9)
                            state <= ACK;     // stop bit just released
                    end
                    ACK: if (fall) begin
                        bit_idx <= 4'd11;
                        state   <= WAIT_IDLE;
                    end
                    WAIT_IDLE: if (filt[0] && filt[1]) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on the pads.
// Parameters are scaled down: 20-cycle inhibit, 300-cycle timeout, filter of 4.
module tb_ps2_host_tx;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, kclk_oe, kdata_oe, busy, done, err;
    logic [1:0] err_code;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    logic       kclk_in, kdata_in;

    int total = 0, bad = 0;
    int done_total = 0, err_total = 0;
    logic [1:0] last_code = 2'b00;
    logic [1:0] err_oe = 2'b00;
    logic [9:0] cap;
    int d0, e0, n;

    assign kclk_in  = dev_clk & ~kclk_oe;
    assign kdata_in = dev_data & ~kdata_oe;

    ps2_host_tx #(.CLK_FREQ_HZ(1_000_000), .INHIBIT_US(20), .TIMEOUT_US(300), .FILTER_LEN(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .kclk_in(kclk_in), .kdata_in(kdata_in), .kclk_oe(kclk_oe), .kdata_oe(kdata_oe),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // pulse monitor
    always @(negedge clk) begin
        if (done) done_total++;
        if (err) begin
            err_total++;
            last_code = err_code;
            err_oe    = {kclk_oe, kdata_oe};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one host transfer with the device clocking 11 edges; optional reset or contention
    task automatic xfer(input logic [7:0] d, input logic ack, input int rst_edge, input logic clash);
        int inh;
        int w;
        logic first_kd, last_kd;
        cap = '0;
        @(negedge clk); tx_data = d; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0; tx_data = 8'h00;
        check("busy_on_accept", 32'(busy), 32'd1);
        check("ready_low_busy", 32'(tx_ready), 32'd0);
        inh = 0; first_kd = kdata_oe; last_kd = 1'b0;
        while (kclk_oe === 1'b1 && inh < 1000) begin
            last_kd = kdata_oe; inh++;
            @(negedge clk);
        end
        check("inhibit_cycles", 32'(inh), 32'd20);
        check("start_not_early", 32'(first_kd), 32'd0);
        check("start_last_inhibit", 32'(last_kd), 32'd1);
        check("req_start_bit", 32'(kdata_oe), 32'd1);
        for (int k = 1; k <= 11; k++) begin
            repeat (10) @(negedge clk);
            dev_data = (k == 11) ? ack : 1'b1;
            repeat (HALF - 10) @(negedge clk);
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            if (k <= 10) cap[k-1] = ~kdata_oe;
            if (k == 4) tx_valid = 1'b1;
            if (k == 5) tx_valid = 1'b0;
            if (k == rst_edge) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_kclk_oe", 32'(kclk_oe), 32'd0);
                check("rst_kdata_oe", 32'(kdata_oe), 32'd0);
                check("rst_tx_ready", 32'(tx_ready), 32'd1);
                check("rst_busy", 32'(busy), 32'd0);
                rst = 1'b0; dev_clk = 1'b1;
                return;
            end
            if (clash && k == 3) dev_data = 1'b0;
            repeat (HALF - 10) @(negedge clk);
            dev_clk = 1'b1;
        end
        repeat (10) @(negedge clk);
        dev_data = 1'b1;
        w = 0;
        while (done_total == d0 && err_total == e0 && w < 300) begin
            @(negedge clk); w++;
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("reset_kclk_oe", 32'(kclk_oe), 32'd0);
        check("reset_kdata_oe", 32'(kdata_oe), 32'd0);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop released
        d0 = done_total; e0 = err_total;
        xfer(8'hED, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("ed_frame", 32'(cap), 32'h3ED);
        check("ed_done_once", 32'(done_total - d0), 32'd1);
        check("ed_no_err", 32'(err_total - e0), 32'd0);
        check("ed_busy_low", 32'(busy), 32'd0);
        check("ed_ready", 32'(tx_ready), 32'd1);
        check("ed_lines_released", 32'({kclk_oe, kdata_oe}), 32'd0);

        // 0x01: parity bit 0
        d0 = done_total; e0 = err_total;
        xfer(8'h01, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("01_frame", 32'(cap), 32'h201);
        check("01_parity", 32'(cap[8]), 32'd0);
        check("01_done_once", 32'(done_total - d0), 32'd1);

        // device never clocks: timeout 300 cycles after REQ entry
        d0 = done_total; e0 = err_total;
        @(negedge clk); tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        n = 0;
        while (kclk_oe === 1'b1 && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        while (err !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        check("to_cycles", 32'(n), 32'd300);
        check("to_err_code", 32'(err_code), 32'd1);
        check("to_lines_released", 32'({kclk_oe, kdata_oe}), 32'd0);
        repeat (3) @(negedge clk);
        check("to_err_once", 32'(err_total - e0), 32'd1);
        check("to_no_done", 32'(done_total - d0), 32'd0);
        check("to_ready", 32'(tx_ready), 32'd1);

        // no ACK: data left high at edge 11
        d0 = done_total; e0 = err_total;
        xfer(8'h3C, 1'b1, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("nack_err_once", 32'(err_total - e0), 32'd1);
        check("nack_code", 32'(last_code), 32'd2);
        check("nack_oe_at_err", 32'(err_oe), 32'd0);
        check("nack_no_done", 32'(done_total - d0), 32'd0);

        // reset at edge 5 of 0xFF, then 0xF4 completes
        d0 = done_total; e0 = err_total;
        xfer(8'hFF, 1'b0, 5, 1'b0);
        repeat (20) @(negedge clk);
        check("rst_no_done", 32'(done_total - d0), 32'd0);
        check("rst_no_err", 32'(err_total - e0), 32'd0);
        d0 = done_total; e0 = err_total;
        xfer(8'hF4, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("f4_frame", 32'(cap), 32'h2F4);
        check("f4_done_once", 32'(done_total - d0), 32'd1);
        check("f4_no_err", 32'(err_total - e0), 32'd0);

`ifdef PS2_TX_LINE_CHECK_EN
        // device forces data low while bit 2 of 0xFF is driven
        d0 = done_total; e0 = err_total;
        xfer(8'hFF, 1'b0, 0, 1'b1);
        repeat (3) @(negedge clk);
        check("clash_err_once", 32'(err_total - e0), 32'd1);
        check("clash_code", 32'(last_code), 32'd3);
        check("clash_oe_at_err", 32'(err_oe), 32'd0);
        check("clash_no_done", 32'(done_total - d0), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
